// File: rtl/vending_machine_param.sv
// Single-product vending controller: accumulates 1/2/5-unit coins, vends one item, returns change serially.
// Optional refund-on-cancel feature is built only when VM_CANCEL_EN is defined.
module vending_machine_param #(
  parameter int PRICE     = 3,
  parameter int CREDIT_W  = 4,
  parameter int STOCK_W   = 4,
  parameter int STOCK_MAX = 10
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                coin_1,
  input  logic                coin_2,
  input  logic                coin_5,
  input  logic                cancel,
  input  logic                restock,
  output logic                out,
  output logic                change_1,
  output logic                change_2,
  output logic                busy,
  output logic                sold_out,
  output logic [CREDIT_W-1:0] credit
);

  localparam logic [CREDIT_W-1:0] LP_PRICE     = CREDIT_W'(PRICE);
  localparam logic [STOCK_W-1:0]  LP_STOCK_MAX = STOCK_W'(STOCK_MAX);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_VEND    = 2'd1,
    S_CHANGE  = 2'd2
  } state_t;

  state_t              r_state;
  logic [CREDIT_W-1:0] r_credit;
  logic [STOCK_W-1:0]  r_stock;
  logic                r_out;
  logic                r_chg1;
  logic                r_chg2;
  logic                r_sold_out;

  logic [3:0]          w_sum;
  logic [CREDIT_W-1:0] w_next;
  logic                w_stock_empty;
  logic                w_cancel;
  logic                w_refund;
  logic                w_vend;
  logic [CREDIT_W-1:0] w_pay_src;
  logic                w_pay2;
  logic [CREDIT_W-1:0] w_pay_rest;

  assign w_sum         = {3'b000, coin_1} + {2'b00, coin_2, 1'b0} + {1'b0, coin_5, 1'b0, coin_5};
  assign w_next        = r_credit + CREDIT_W'(w_sum);
  assign w_stock_empty = (r_stock == '0);

`ifdef VM_CANCEL_EN
  assign w_cancel = cancel && (w_next != '0);
`else
  logic w_unused_cancel;
  assign w_unused_cancel = cancel;
  assign w_cancel        = 1'b0;
`endif

  // A refund (sold out or cancel) wins over vending on the same edge.
  assign w_refund = (w_stock_empty && (w_sum != 4'd0)) || w_cancel;
  assign w_vend   = !w_refund && (w_next >= LP_PRICE);

  // Next change coin: a refund pays from the fresh total, otherwise from the held remainder.
  assign w_pay_src  = (r_state == S_COLLECT) ? w_next : r_credit;
  assign w_pay2     = (w_pay_src >= CREDIT_W'(2));
  assign w_pay_rest = w_pay2 ? (w_pay_src - CREDIT_W'(2)) : (w_pay_src - CREDIT_W'(1));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_COLLECT;
      r_credit   <= '0;
      r_stock    <= LP_STOCK_MAX;
      r_out      <= 1'b0;
      r_chg1     <= 1'b0;
      r_chg2     <= 1'b0;
      r_sold_out <= 1'b0;
    end else begin
      r_out      <= 1'b0;
      r_chg1     <= 1'b0;
      r_chg2     <= 1'b0;
      r_sold_out <= w_stock_empty;
      case (r_state)
        S_COLLECT: begin
          if (w_refund) begin
            r_state  <= S_CHANGE;
            r_chg2   <= w_pay2;
            r_chg1   <= !w_pay2;
            r_credit <= w_pay_rest;
          end else if (w_vend) begin
            r_state  <= S_VEND;
            r_out    <= 1'b1;
            r_credit <= w_next - LP_PRICE;
          end else begin
            r_credit <= w_next;
          end
        end
        S_VEND: begin
          r_stock <= r_stock - 1'b1;
          if (r_credit != '0) begin
            r_state  <= S_CHANGE;
            r_chg2   <= w_pay2;
            r_chg1   <= !w_pay2;
            r_credit <= w_pay_rest;
          end else begin
            r_state <= S_COLLECT;
          end
        end
        S_CHANGE: begin
          if (r_credit == '0) begin
            r_state <= S_COLLECT;
          end else begin
            r_chg2   <= w_pay2;
            r_chg1   <= !w_pay2;
            r_credit <= w_pay_rest;
          end
        end
        default: begin
          r_state  <= S_COLLECT;
          r_credit <= '0;
        end
      endcase
      // Restock overrides the vend decrement on the same edge.
      if (restock) r_stock <= LP_STOCK_MAX;
    end
  end

  assign out      = r_out;
  assign change_1 = r_chg1;
  assign change_2 = r_chg2;
  assign busy     = (r_state != S_COLLECT);
  assign sold_out = r_sold_out;
  assign credit   = r_credit;

endmodule

// File: tb/tb_vending_machine_param.sv
// Directed bench for vending_machine_param with PRICE=3, STOCK_MAX=2.
// Inputs {reset,coin_1,coin_2,coin_5,cancel,restock}; outputs {out,change_1,change_2,busy,sold_out,credit[3:0]}.
module tb_vending_machine_param;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       coin_1 = 1'b0, coin_2 = 1'b0, coin_5 = 1'b0;
  logic       cancel = 1'b0, restock = 1'b0;
  logic       out, change_1, change_2, busy, sold_out;
  logic [3:0] credit;

  int errors = 0;
  int checks = 0;

  vending_machine_param #(
    .PRICE(3), .CREDIT_W(4), .STOCK_W(4), .STOCK_MAX(2)
  ) dut (
    .clock(clock), .reset(reset),
    .coin_1(coin_1), .coin_2(coin_2), .coin_5(coin_5),
    .cancel(cancel), .restock(restock),
    .out(out), .change_1(change_1), .change_2(change_2),
    .busy(busy), .sold_out(sold_out), .credit(credit)
  );

  always #5 clock = ~clock;

  typedef struct {
    string      name;
    logic [5:0] in;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input string n, input logic [5:0] i, input logic [8:0] e);
    vec_t v;
    v.name = n;
    v.in   = i;
    v.exp  = e;
    return v;
  endfunction

  task automatic cyc(input string nm, input logic [5:0] in, input logic [8:0] exp);
    logic [8:0] act;
    {reset, coin_1, coin_2, coin_5, cancel, restock} = in;
    @(posedge clock);
    #1;
    act = {out, change_1, change_2, busy, sold_out, credit};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b required %b", nm, act, exp);
    end
    {reset, coin_1, coin_2, coin_5, cancel, restock} = 6'b0;
  endtask

  initial begin
    //                     rst c1 c2 c5 can rs     out c1 c2 bsy so credit
    tbl.push_back(mk("rst0",   6'b1_0_0_0_0_0, 9'b0_0_0_0_0_0000));
    tbl.push_back(mk("rst1",   6'b1_0_0_0_0_0, 9'b0_0_0_0_0_0000));
    tbl.push_back(mk("idle",   6'b0_0_0_0_0_0, 9'b0_0_0_0_0_0000));
    tbl.push_back(mk("A_c2",   6'b0_0_1_0_0_0, 9'b0_0_0_0_0_0010));
    tbl.push_back(mk("A_vend", 6'b0_0_1_0_0_0, 9'b1_0_0_1_0_0001));
    tbl.push_back(mk("A_chg1", 6'b0_0_0_0_0_0, 9'b0_1_0_1_0_0000));
    tbl.push_back(mk("A_done", 6'b0_0_0_0_0_0, 9'b0_0_0_0_0_0000));
    tbl.push_back(mk("B_vend", 6'b0_0_1_1_0_0, 9'b1_0_0_1_0_0100));
    tbl.push_back(mk("B_chg2a",6'b0_0_0_0_0_0, 9'b0_0_1_1_0_0010));
    tbl.push_back(mk("B_chg2b",6'b0_0_0_0_0_0, 9'b0_0_1_1_1_0000));
    tbl.push_back(mk("B_done", 6'b0_0_0_0_0_0, 9'b0_0_0_0_1_0000));
    tbl.push_back(mk("C_ref2a",6'b0_0_0_1_0_0, 9'b0_0_1_1_1_0011));
    tbl.push_back(mk("C_ref2b",6'b0_0_0_0_0_0, 9'b0_0_1_1_1_0001));
    tbl.push_back(mk("C_ref1", 6'b0_0_0_0_0_0, 9'b0_1_0_1_1_0000));
    tbl.push_back(mk("C_done", 6'b0_0_0_0_0_0, 9'b0_0_0_0_1_0000));
    tbl.push_back(mk("C_rstk", 6'b0_0_0_0_0_1, 9'b0_0_0_0_1_0000));
    tbl.push_back(mk("C_soclr",6'b0_0_0_0_0_0, 9'b0_0_0_0_0_0000));
    tbl.push_back(mk("C_vend", 6'b0_1_1_0_0_0, 9'b1_0_0_1_0_0000));
    tbl.push_back(mk("C_back", 6'b0_0_0_0_0_0, 9'b0_0_0_0_0_0000));
    tbl.push_back(mk("D_vend", 6'b0_0_0_1_0_0, 9'b1_0_0_1_0_0010));
    tbl.push_back(mk("D_ignV", 6'b0_0_0_1_0_0, 9'b0_0_1_1_0_0000));
    tbl.push_back(mk("D_ignC", 6'b0_0_0_1_0_0, 9'b0_0_0_0_1_0000));
    tbl.push_back(mk("D_cr0",  6'b0_0_0_0_0_0, 9'b0_0_0_0_1_0000));
    tbl.push_back(mk("D_rstk", 6'b0_0_0_0_0_1, 9'b0_0_0_0_1_0000));
    tbl.push_back(mk("D_soclr",6'b0_0_0_0_0_0, 9'b0_0_0_0_0_0000));
    tbl.push_back(mk("E_vend", 6'b0_1_0_1_0_0, 9'b1_0_0_1_0_0011));
    tbl.push_back(mk("E_chg2", 6'b0_0_0_0_0_0, 9'b0_0_1_1_0_0001));
    tbl.push_back(mk("E_chg1", 6'b0_0_0_0_0_0, 9'b0_1_0_1_0_0000));
    tbl.push_back(mk("E_done", 6'b0_0_0_0_0_0, 9'b0_0_0_0_0_0000));
    tbl.push_back(mk("F_vend", 6'b0_1_1_0_0_0, 9'b1_0_0_1_0_0000));
    tbl.push_back(mk("F_rsvnd",6'b0_0_0_0_0_1, 9'b0_0_0_0_0_0000));
    tbl.push_back(mk("F_buy1", 6'b0_1_1_0_0_0, 9'b1_0_0_1_0_0000));
    tbl.push_back(mk("F_b1end",6'b0_0_0_0_0_0, 9'b0_0_0_0_0_0000));
    tbl.push_back(mk("F_buy2", 6'b0_1_1_0_0_0, 9'b1_0_0_1_0_0000));
    tbl.push_back(mk("F_b2end",6'b0_0_0_0_0_0, 9'b0_0_0_0_0_0000));
    tbl.push_back(mk("F_so",   6'b0_0_0_0_0_0, 9'b0_0_0_0_1_0000));
    tbl.push_back(mk("F_rstk", 6'b0_0_0_0_0_1, 9'b0_0_0_0_1_0000));
    tbl.push_back(mk("F_soclr",6'b0_0_0_0_0_0, 9'b0_0_0_0_0_0000));
    tbl.push_back(mk("G_c1a",  6'b0_1_0_0_0_0, 9'b0_0_0_0_0_0001));
    tbl.push_back(mk("G_c1b",  6'b0_1_0_0_0_0, 9'b0_0_0_0_0_0010));
    tbl.push_back(mk("G_hold", 6'b0_0_0_0_0_0, 9'b0_0_0_0_0_0010));
    tbl.push_back(mk("G_vend", 6'b0_1_0_0_0_0, 9'b1_0_0_1_0_0000));
    tbl.push_back(mk("G_done", 6'b0_0_0_0_0_0, 9'b0_0_0_0_0_0000));

    for (int i = 0; i < tbl.size(); i++) cyc(tbl[i].name, tbl[i].in, tbl[i].exp);

    // Cancel together with a coin; stock is 1 here.
    cyc("H_c1",   6'b0_1_0_0_0_0, 9'b0_0_0_0_0_0001);
`ifdef VM_CANCEL_EN
    cyc("H_cncl", 6'b0_0_1_0_1_0, 9'b0_0_1_1_0_0001);
    cyc("H_chg1", 6'b0_0_0_0_0_0, 9'b0_1_0_1_0_0000);
    cyc("H_done", 6'b0_0_0_0_0_0, 9'b0_0_0_0_0_0000);
`else
    cyc("H_vend", 6'b0_0_1_0_1_0, 9'b1_0_0_1_0_0000);
    cyc("H_done", 6'b0_0_0_0_0_0, 9'b0_0_0_0_0_0000);
    cyc("H_so",   6'b0_0_0_0_0_0, 9'b0_0_0_0_1_0000);
`endif
    cyc("H_rst",  6'b1_0_0_0_0_0, 9'b0_0_0_0_0_0000);

    // Reset during the first change cycle with remainder 4, then prove stock reloaded to 2.
    cyc("R_vend", 6'b0_0_1_1_0_0, 9'b1_0_0_1_0_0100);
    cyc("R_chg2", 6'b0_0_0_0_0_0, 9'b0_0_1_1_0_0010);
    cyc("R_rst",  6'b1_0_0_0_0_0, 9'b0_0_0_0_0_0000);
    cyc("R_q1",   6'b0_0_0_0_0_0, 9'b0_0_0_0_0_0000);
    cyc("R_q2",   6'b0_0_0_0_0_0, 9'b0_0_0_0_0_0000);
    cyc("R_buy1", 6'b0_1_1_0_0_0, 9'b1_0_0_1_0_0000);
    cyc("R_b1end",6'b0_0_0_0_0_0, 9'b0_0_0_0_0_0000);
    cyc("R_buy2", 6'b0_1_1_0_0_0, 9'b1_0_0_1_0_0000);
    cyc("R_b2end",6'b0_0_0_0_0_0, 9'b0_0_0_0_0_0000);
    cyc("R_so",   6'b0_0_0_0_0_0, 9'b0_0_0_0_1_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
